ahb_arbiter_rr: RTL and testbench

Parametrised AHB bus arbiter; successor to the fixed 16-master arbiter. It supports a configurable master count, a fixed-priority or round-robin policy, and SPLIT masking driven by HRESP/HSPLIT. It also enforces a per-master tenure limit for unlocked traffic. It sits between the master request lines and the address/data multiplexers, and drives HGRANTx, HMASTER and HMASTLOCK.

---
 rtl/ahb_arb_pkg.sv | 14 +
 rtl/ahb_arb_picker.sv | 27 ++
 rtl/ahb_arbiter_rr.sv | 113 +++++++++++
 tb/tb_ahb_arbiter_rr.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter definitions: HRESP encodings and arbitration policy.
package ahb_arb_pkg;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational rotating-priority picker: first eligible index at or after i_start.
module ahb_arb_picker #(
  parameter int unsigned NUM_MASTERS = 16,
  localparam int unsigned MW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_elig,
  input  logic [MW-1:0]          i_start,
  output logic [NUM_MASTERS-1:0] o_onehot,
  output logic                   o_valid
);

  logic [MW-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_idx = MW'((32'(i_start) + 32'(k)) % NUM_MASTERS);
      if (!o_valid && i_elig[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        o_valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// Parametrised AHB arbiter: fixed or round-robin policy, SPLIT masking,
// bus lock and a per-master tenure limit for unlocked traffic.
module ahb_arbiter_rr
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 16,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter arb_mode_e   MODE           = ARB_FIXED,
  parameter int unsigned MAX_HOLD       = 16,
  localparam int unsigned MW = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [NUM_MASTERS-1:0] DEF_OH = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant, r_mask;
  logic [MW-1:0]          r_hmaster, r_ptr;
  logic                   r_hmastlock;
  logic [CW-1:0]          r_cnt;

  logic [NUM_MASTERS-1:0] w_elig, w_cand, w_pick, w_grant_nxt, w_split_set;
  logic [MW-1:0]          w_g, w_start, w_ptr_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_lock, w_others, w_expire, w_sticky, w_pick_vld;

  function automatic logic [MW-1:0] f_idx(input logic [NUM_MASTERS-1:0] v);
    f_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (v[i]) f_idx = MW'(i);
  endfunction

  assign w_g      = f_idx(r_grant);
  assign w_elig   = HBUSREQx & ~r_mask;
  assign w_others = |(w_elig & ~r_grant);
  assign w_lock   = |(HLOCKx & r_grant);
  assign w_expire = (MAX_HOLD != 0) && w_others && (r_cnt == LIMIT);
  // A masked owner is simply not eligible, so stickiness drops out on its own.
  assign w_sticky = (|(w_elig & r_grant)) && !w_expire;
  assign w_cand   = w_elig & ~r_grant;
  assign w_start  = (MODE == ARB_RR) ? MW'((32'(r_ptr) + 32'd1) % NUM_MASTERS) : '0;

  assign w_split_set = (!HREADY && HRESP == SPLIT) ? (NUM_MASTERS'(1) << r_hmaster) : '0;

  ahb_arb_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .i_elig   (w_cand),
    .i_start  (w_start),
    .o_onehot (w_pick),
    .o_valid  (w_pick_vld)
  );

  always_comb begin
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    if (!w_lock) begin
      if (w_sticky) begin
        if (w_others) begin
          if (MAX_HOLD != 0) w_cnt_nxt = r_cnt + CW'(1);
        end else if (r_cnt == LIMIT) begin
          w_cnt_nxt = '0;
        end
      end else begin
        w_cnt_nxt = '0;
        if (w_pick_vld) begin
          w_grant_nxt = w_pick;
          if (MODE == ARB_RR) w_ptr_nxt = f_idx(w_pick);
        end else begin
          w_grant_nxt = DEF_OH;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_grant     <= DEF_OH;
      r_hmaster   <= MW'(DEFAULT_MASTER);
      r_hmastlock <= 1'b0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_ptr       <= MW'(DEFAULT_MASTER);
    end else begin
      // Clear beats set when both hit the same master in one cycle.
      r_mask <= (r_mask | w_split_set) & ~HSPLIT;
      if (HREADY) begin
        r_grant     <= w_grant_nxt;
        r_cnt       <= w_cnt_nxt;
        r_ptr       <= w_ptr_nxt;
        r_hmaster   <= w_g;
        r_hmastlock <= w_lock;
      end
    end
  end

  assign HGRANTx   = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_hmastlock;

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(r_grant));

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: a fixed-priority and a round-robin
// instance (4 masters, default master 2, tenure limit 2) share one stimulus.
module tb_ahb_arbiter_rr;
  import ahb_arb_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESET, HREADY;
  logic [3:0] HBUSREQx, HLOCKx, HSPLIT;
  logic [1:0] HRESP;

  logic [3:0] fx_grant, rr_grant;
  logic [1:0] fx_master, rr_master;
  logic       fx_lock, rr_lock;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_rr #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .MODE(ARB_FIXED), .MAX_HOLD(2)) u_fix (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
    .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(fx_grant), .HMASTER(fx_master), .HMASTLOCK(fx_lock)
  );

  ahb_arbiter_rr #(.NUM_MASTERS(4), .DEFAULT_MASTER(2), .MODE(ARB_RR), .MAX_HOLD(2)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
    .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(rr_grant), .HMASTER(rr_master), .HMASTLOCK(rr_lock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1; HREADY = 1'b1; HRESP = OKAY;
    HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0;
    step();
    step();
    HRESET = 1'b0;
  endtask

  int exp_rr [11] = '{2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
  int prev;

  initial begin
    // Reset and default master
    do_reset();
    check("rst_fx_grant", fx_grant, 4'b0100);
    check("rst_fx_master", fx_master, 2);
    check("rst_fx_lock", fx_lock, 0);
    check("rst_rr_grant", rr_grant, 4'b0100);
    check("rst_rr_master", rr_master, 2);
    repeat (3) step();
    check("idle_fx_grant", fx_grant, 4'b0100);
    check("idle_fx_master", fx_master, 2);

    // Fixed priority with tenure hand-off between masters 1 and 3
    HBUSREQx = 4'b1010;
    step();
    check("fix_grant1", fx_grant, 4'b0010);
    check("fix_master_lag", fx_master, 2);
    step();
    check("fix_hold1", fx_grant, 4'b0010);
    check("fix_master1", fx_master, 1);
    step();
    check("fix_tenure_to3", fx_grant, 4'b1000);
    step();
    check("fix_master3", fx_master, 3);
    step();
    check("fix_tenure_to1", fx_grant, 4'b0010);

    // Round robin, all requesting, two edges per tenure
    do_reset();
    HBUSREQx = 4'b1111;
    prev = 2;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("rr_grant_%0d", i), rr_grant, 32'(1) << exp_rr[i]);
      check($sformatf("rr_master_%0d", i), rr_master, prev);
      prev = exp_rr[i];
    end

    // Lock holds past tenure, then wait states freeze everything
    do_reset();
    HBUSREQx = 4'b0010;
    step();
    check("lk_grant1", fx_grant, 4'b0010);
    HBUSREQx = 4'b0011; HLOCKx = 4'b0010;
    step();
    check("lk_master", fx_master, 1);
    check("lk_mastlock", fx_lock, 1);
    repeat (3) step();
    check("lk_past_hold", fx_grant, 4'b0010);
    HREADY = 1'b0; HBUSREQx = 4'b0001; HLOCKx = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ws_grant_%0d", i), fx_grant, 4'b0010);
      check($sformatf("ws_master_%0d", i), fx_master, 1);
      check($sformatf("ws_lock_%0d", i), fx_lock, 1);
    end
    HREADY = 1'b1;
    step();
    check("unlk_grant0", fx_grant, 4'b0001);
    check("unlk_mastlock", fx_lock, 0);
    step();
    check("unlk_master0", fx_master, 0);

    // SPLIT masks master 3, HSPLIT restores it
    do_reset();
    HBUSREQx = 4'b1000;
    step();
    check("sp_grant3", fx_grant, 4'b1000);
    step();
    check("sp_master3", fx_master, 3);
    HREADY = 1'b0; HRESP = SPLIT; HBUSREQx = 4'b1001;
    step();
    check("sp_wait_grant", fx_grant, 4'b1000);
    HREADY = 1'b1; HRESP = OKAY;
    step();
    check("sp_regrant0", fx_grant, 4'b0001);
    step();
    check("sp_masked_hold0", fx_grant, 4'b0001);
    HSPLIT = 4'b1000;
    step();
    HSPLIT = 4'b0000;
    step();
    check("sp_unmask_hold0", fx_grant, 4'b0001);
    step();
    check("sp_unmask_to3", fx_grant, 4'b1000);
    step();
    check("sp_master3b", fx_master, 3);
    HREADY = 1'b0; HRESP = SPLIT; HSPLIT = 4'b1000;
    step();
    HREADY = 1'b1; HRESP = OKAY; HSPLIT = 4'b0000; HBUSREQx = 4'b1000;
    step();
    check("sp_clear_wins", fx_grant, 4'b1000);

    // Reset during a wait state
    HREADY = 1'b0; HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("rst_ws_grant", fx_grant, 4'b0100);
    check("rst_ws_master", fx_master, 2);
    check("rst_ws_lock", fx_lock, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
